led_pio_arbiter: RTL and testbench

//  Round-robin arbiter that shares the 8-bit LEDR display between NREQ requesters,
//  e.g. Nios II PIO export, hardware binary counter and switch passthrough.

---
 rtl/led_pio_arbiter.sv | 132 +++++++++++++
 tb/tb_led_pio_arbiter.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/led_pio_arbiter.sv
// Round-robin arbiter sharing the LED display between NREQ requesters.
// Each grant owns the display for DWELL cycles; the last value persists in IDLE.
// Optional feature macro: LED_ARB_LOCK_EN adds a per-requester lock input that lets
// the current owner extend its tenure (and refresh its data) at expiry.
module led_pio_arbiter #(
  parameter int unsigned NREQ  = 3,
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DWELL = 50_000_000
) (
  input  logic                    clk_clk,
  input  logic                    reset_reset_n,
  input  logic [NREQ-1:0]         req_valid,
  input  logic [NREQ*WIDTH-1:0]   req_data,
  output logic [NREQ-1:0]         req_ready,
  output logic [WIDTH-1:0]        led_out,
  output logic [$clog2(NREQ)-1:0] owner,
  output logic                    busy
`ifdef LED_ARB_LOCK_EN
  ,
  input  logic [NREQ-1:0]         lock
`endif
);

  localparam int unsigned OW = $clog2(NREQ);
  localparam int unsigned CW = $clog2(DWELL + 1);

  typedef enum logic [0:0] {StIdle, StHold} state_e;

  state_e            state_q, state_d;
  logic [WIDTH-1:0]  led_q, led_d;
  logic [NREQ-1:0]   ready_q, ready_d;
  logic [OW-1:0]     owner_q, owner_d;
  logic              busy_q, busy_d;
  logic [OW-1:0]     rr_ptr_q, rr_ptr_d;
  logic [CW-1:0]     dwell_q, dwell_d;

  logic [WIDTH-1:0]  data_arr [NREQ];
  logic              found;
  logic [OW-1:0]     sel;
  logic [31:0]       idx;

  // Unpack the flat request data bus into per-requester words.
  always_comb begin
    for (int unsigned i = 0; i < NREQ; i++) begin
      data_arr[i] = req_data[i*WIDTH +: WIDTH];
    end
  end

  // Pick the first valid requester scanning from rr_ptr with wrap-around.
  always_comb begin
    found = 1'b0;
    sel   = '0;
    idx   = '0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      idx = 32'(rr_ptr_q) + k;
      if (idx >= NREQ) idx = idx - NREQ;
      if (!found && req_valid[OW'(idx)]) begin
        found = 1'b1;
        sel   = OW'(idx);
      end
    end
  end

  // Next-state and registered-output logic for the IDLE/HOLD tenure FSM.
  always_comb begin
    state_d  = state_q;
    led_d    = led_q;
    ready_d  = '0;
    owner_d  = owner_q;
    busy_d   = busy_q;
    rr_ptr_d = rr_ptr_q;
    dwell_d  = dwell_q;
    unique case (state_q)
      StIdle: begin
        if (found) begin
          led_d        = data_arr[sel];
          ready_d[sel] = 1'b1;
          owner_d      = sel;
          busy_d       = 1'b1;
          dwell_d      = CW'(DWELL - 1);
          state_d      = StHold;
        end
      end
      StHold: begin
        if (dwell_q != '0) begin
          dwell_d = dwell_q - 1'b1;
`ifdef LED_ARB_LOCK_EN
        end else if (lock[owner_q]) begin
          // Locked owner keeps the display; it may refresh its data at each expiry.
          dwell_d = CW'(DWELL - 1);
          if (req_valid[owner_q]) begin
            led_d            = data_arr[owner_q];
            ready_d[owner_q] = 1'b1;
          end
`endif
        end else begin
          busy_d   = 1'b0;
          state_d  = StIdle;
          rr_ptr_d = (owner_q == OW'(NREQ - 1)) ? '0 : owner_q + 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk_clk) begin
    if (!reset_reset_n) begin
      state_q  <= StIdle;
      led_q    <= '0;
      ready_q  <= '0;
      owner_q  <= '0;
      busy_q   <= 1'b0;
      rr_ptr_q <= '0;
      dwell_q  <= '0;
    end else begin
      state_q  <= state_d;
      led_q    <= led_d;
      ready_q  <= ready_d;
      owner_q  <= owner_d;
      busy_q   <= busy_d;
      rr_ptr_q <= rr_ptr_d;
      dwell_q  <= dwell_d;
    end
  end

  assign req_ready = ready_q;
  assign led_out   = led_q;
  assign owner     = owner_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_led_pio_arbiter.sv
// Scoreboard bench for led_pio_arbiter (NREQ=3, WIDTH=8, DWELL=4).
// Stimulus pushes expected grants into a queue; a negedge monitor pops on each ready.
module tb_led_pio_arbiter;

  logic        clk;
  logic        rst_n;
  logic [2:0]  v;
  logic [23:0] d;
  logic [2:0]  rdy;
  logic [7:0]  led;
  logic [1:0]  own;
  logic        bsy;
  logic [2:0]  lk;

  int nerr = 0;
  int nchk = 0;
  bit mon_en = 0;

  typedef struct {
    logic [2:0] rdy;
    logic [7:0] led;
    logic [1:0] own;
  } exp_t;

  exp_t q[$];
  exp_t e;

  led_pio_arbiter #(.NREQ(3), .WIDTH(8), .DWELL(4)) dut (
    .clk_clk       (clk),
    .reset_reset_n (rst_n),
    .req_valid     (v),
    .req_data      (d),
    .req_ready     (rdy),
    .led_out       (led),
    .owner         (own),
    .busy          (bsy)
`ifdef LED_ARB_LOCK_EN
    ,
    .lock          (lk)
`endif
  );

  initial clk = 0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    nchk++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [2:0] r, input logic [7:0] l, input logic [1:0] o);
    exp_t x;
    x.rdy = r;
    x.led = l;
    x.own = o;
    q.push_back(x);
  endtask

  // Monitor: every ready pulse must match the next expected grant.
  always @(negedge clk) begin
    if (mon_en && rdy !== 3'b000) begin
      if (q.size() == 0) begin
        chk("unexpected_ready", 32'(rdy), 32'h0);
      end else begin
        e = q.pop_front();
        chk("sb_ready", 32'(rdy), 32'(e.rdy));
        chk("sb_led", 32'(led), 32'(e.led));
        chk("sb_owner", 32'(own), 32'(e.own));
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 0;
    v = '0;
    d = '0;
    lk = '0;

    // 1: reset with random requests
    @(posedge clk); #1;
    v = 3'($urandom);
    d = 24'($urandom);
    tick(2);
    chk("rst_led", 32'(led), 0);
    chk("rst_ready", 32'(rdy), 0);
    chk("rst_busy", 32'(bsy), 0);
    chk("rst_owner", 32'(own), 0);
    v = '0;
    rst_n = 1;
    mon_en = 1;
    tick(1);

    // 2: single request from requester 1
    v = 3'b010;
    d[15:8] = 8'hA5;
    push(3'b010, 8'hA5, 2'd1);
    tick(1);
    v = '0;
    chk("single_ready", 32'(rdy), 32'h2);
    chk("single_busy0", 32'(bsy), 1);
    tick(3);
    chk("single_busy3", 32'(bsy), 1);
    tick(1);
    chk("single_busy_end", 32'(bsy), 0);
    chk("single_led_hold", 32'(led), 32'hA5);
    tick(2);
    chk("single_led_persist", 32'(led), 32'hA5);

    // 3: round robin from rr_ptr=0
    rst_n = 0;
    tick(1);
    rst_n = 1;
    v = 3'b111;
    d = 24'h332211;
    push(3'b001, 8'h11, 2'd0);
    push(3'b010, 8'h22, 2'd1);
    push(3'b100, 8'h33, 2'd2);
    push(3'b001, 8'h11, 2'd0);
    tick(1);
    chk("rr_g0", 32'(rdy), 32'h1);
    tick(5);
    chk("rr_g1", 32'(rdy), 32'h2);
    tick(5);
    chk("rr_g2", 32'(rdy), 32'h4);
    tick(5);
    chk("rr_g3", 32'(rdy), 32'h1);
    v = '0;
    tick(6);

    // 4: contention, req2 arrives while req0 holds
    v = 3'b001;
    d[7:0] = 8'h44;
    push(3'b001, 8'h44, 2'd0);
    tick(1);
    v = '0;
    chk("cont_g0", 32'(rdy), 32'h1);
    tick(1);
    v[2] = 1'b1;
    d[23:16] = 8'h3C;
    push(3'b100, 8'h3C, 2'd2);
    for (int i = 0; i < 3; i++) begin
      tick(1);
      chk("cont_wait", 32'(rdy), 0);
    end
    chk("cont_busy_end", 32'(bsy), 0);
    chk("cont_led_old", 32'(led), 32'h44);
    tick(1);
    chk("cont_g2", 32'(rdy), 32'h4);
    chk("cont_led", 32'(led), 32'h3C);
    v = '0;
    tick(6);

    // 5: reset mid-HOLD with dwell=2
    v = 3'b010;
    d[15:8] = 8'h77;
    push(3'b010, 8'h77, 2'd1);
    tick(1);
    v = '0;
    tick(1);
    rst_n = 0;
    tick(1);
    chk("mrst_busy", 32'(bsy), 0);
    chk("mrst_led", 32'(led), 0);
    chk("mrst_ready", 32'(rdy), 0);
    rst_n = 1;
    v = 3'b110;
    d[15:8] = 8'h81;
    d[23:16] = 8'h82;
    push(3'b010, 8'h81, 2'd1);
    tick(1);
    chk("mrst_g1", 32'(rdy), 32'h2);
    v = 3'b100;
    push(3'b100, 8'h82, 2'd2);
    tick(5);
    chk("mrst_g2", 32'(rdy), 32'h4);
    v = '0;
    tick(6);

`ifdef LED_ARB_LOCK_EN
    // 6: locked owner refreshes and starves req1
    rst_n = 0;
    tick(1);
    rst_n = 1;
    v = 3'b001;
    d[7:0] = 8'h10;
    push(3'b001, 8'h10, 2'd0);
    tick(1);
    lk = 3'b001;
    v = 3'b010;
    d[15:8] = 8'h99;
    tick(3);
    v[0] = 1'b1;
    d[7:0] = 8'h5A;
    push(3'b001, 8'h5A, 2'd0);
    tick(1);
    chk("lock_ready", 32'(rdy), 32'h1);
    chk("lock_led", 32'(led), 32'h5A);
    chk("lock_busy", 32'(bsy), 1);
    v[0] = 1'b0;
    tick(4);
    chk("lock_ext_busy", 32'(bsy), 1);
    chk("lock_ext_ready", 32'(rdy), 0);
    lk = '0;
    push(3'b010, 8'h99, 2'd1);
    tick(4);
    chk("unlock_busy", 32'(bsy), 0);
    tick(1);
    chk("unlock_g1", 32'(rdy), 32'h2);
    v = '0;
    tick(6);
`endif

    tick(2);
    chk("sb_drained", 32'(q.size()), 0);
    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
